// File: rtl/sysctl_icap_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sysctl_icap_seq_pkg
// Brief   : ICAP command words and sequencer state types.
// Revision: 1.0
// ============================================================================
package sysctl_icap_seq_pkg;

    localparam logic [15:0] C_DUMMY     = 16'hFFFF;
    localparam logic [15:0] C_SYNC0     = 16'hAA99;
    localparam logic [15:0] C_SYNC1     = 16'h5566;
    localparam logic [15:0] C_WR_GEN1   = 16'h3261;
    localparam logic [15:0] C_WR_GEN2   = 16'h3281;
    localparam logic [15:0] C_WR_CMD    = 16'h30A1;
    localparam logic [15:0] C_CMD_IPROG = 16'h000E;
    localparam logic [15:0] C_NOOP      = 16'h2000;

    localparam logic [3:0]  C_LAST_IDX  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    typedef enum logic {
        M_SEQ = 1'b0,
        M_RAW = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/sysctl_icap_seq_iprog_rom.sv
`default_nettype none
// ============================================================================
// Module  : sysctl_iprog_rom
// Brief   : Combinational IPROG command stream table (word index -> word).
// Revision: 1.0
// ============================================================================
module sysctl_iprog_rom
    import sysctl_icap_seq_pkg::*;
(
    input  logic [3:0]  i_idx,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_opcode,
    output logic [15:0] o_word
);

    always_comb begin
        o_word = C_DUMMY;
        case (i_idx)
            4'd0:    o_word = C_DUMMY;
            4'd1:    o_word = C_SYNC0;
            4'd2:    o_word = C_SYNC1;
            4'd3:    o_word = C_WR_GEN1;
            4'd4:    o_word = i_addr[15:0];
            4'd5:    o_word = C_WR_GEN2;
            4'd6:    o_word = {i_opcode, i_addr[23:16]};
            4'd7:    o_word = C_WR_CMD;
            4'd8:    o_word = C_CMD_IPROG;
            4'd9:    o_word = C_NOOP;
            default: o_word = C_DUMMY;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sysctl_icap_seq.sv
`default_nettype none
// ============================================================================
// Module  : sysctl_icap_seq
// Brief   : IPROG reboot sequencer / raw-write arbiter for the ICAP word port.
// Revision: 1.0
// ============================================================================
module sysctl_icap_seq
    import sysctl_icap_seq_pkg::*;
#(
    parameter logic [7:0]  SPI_OPCODE = 8'h03,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        reboot,
    input  logic [23:0] boot_addr,
    input  logic        raw_we,
    input  logic [15:0] raw_d,
    input  logic        raw_ce,
    input  logic        raw_write,
    output logic        busy,
    output logic        timeout,
    input  logic        icap_ready,
    output logic        icap_we,
    output logic [15:0] icap_d,
    output logic        icap_ce,
    output logic        icap_write
);

    localparam int unsigned       WDOG_W     = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] C_WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    state_t            r_state;
    mode_t             r_mode;
    logic [3:0]        r_idx;
    logic [23:0]       r_addr;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;
    logic [15:0]       r_d;
    logic              r_ce;
    logic              r_write;

    logic [3:0]        w_rom_idx;
    logic [23:0]       w_rom_addr;
    logic [15:0]       w_rom_word;

    // ROM is addressed with the index of the word about to be loaded.
    assign w_rom_idx  = (r_state == S_WAIT) ? (r_idx + 4'd1) : 4'd0;
    assign w_rom_addr = (r_state == S_IDLE) ? boot_addr : r_addr;

    sysctl_iprog_rom u_rom (
        .i_idx    (w_rom_idx),
        .i_addr   (w_rom_addr),
        .i_opcode (SPI_OPCODE),
        .o_word   (w_rom_word)
    );

    assign icap_we    = (r_state == S_ISSUE) && icap_ready;
    assign busy       = (r_state != S_IDLE);
    assign timeout    = r_timeout;
    assign icap_d     = r_d;
    assign icap_ce    = r_ce;
    assign icap_write = r_write;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= M_SEQ;
            r_idx     <= 4'd0;
            r_addr    <= 24'd0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_d       <= 16'hFFFF;
            r_ce      <= 1'b1;
            r_write   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reboot) begin
                        r_addr    <= boot_addr;
                        r_mode    <= M_SEQ;
                        r_idx     <= 4'd0;
                        r_timeout <= 1'b0;
                        r_d       <= w_rom_word;
                        r_ce      <= 1'b0;
                        r_write   <= 1'b0;
                        r_state   <= S_ISSUE;
                    end else if (raw_we) begin
                        r_mode    <= M_RAW;
                        r_d       <= raw_d;
                        r_ce      <= raw_ce;
                        r_write   <= raw_write;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (icap_ready) begin
                        r_state <= S_HOLD;
                    end
                end
                // Port lowers ready one cycle after we; skip that cycle.
                S_HOLD: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (icap_ready) begin
                        if ((r_mode == M_SEQ) && (r_idx < C_LAST_IDX)) begin
                            r_idx   <= r_idx + 4'd1;
                            r_d     <= w_rom_word;
                            r_state <= S_ISSUE;
                        end else begin
                            r_ce    <= 1'b1;
                            r_write <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (r_wdog == C_WDOG_MAX) begin
                        r_timeout <= 1'b1;
                        r_ce      <= 1'b1;
                        r_write   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysctl_icap_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sysctl_icap_seq
// Brief   : Directed self-checking bench for sysctl_icap_seq with a port model.
// Revision: 1.0
// ============================================================================
module tb_sysctl_icap_seq;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        reboot     = 1'b0;
    logic [23:0] boot_addr  = 24'd0;
    logic        raw_we     = 1'b0;
    logic [15:0] raw_d      = 16'd0;
    logic        raw_ce     = 1'b1;
    logic        raw_write  = 1'b1;
    logic        busy;
    logic        timeout;
    logic        icap_ready;
    logic        icap_we;
    logic [15:0] icap_d;
    logic        icap_ce;
    logic        icap_write;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    logic [2:0]  port_cnt  = 3'd0;
    logic        we_q      = 1'b0;
    logic        force_low = 1'b0;

    int          nlog = 0;
    int          log_cyc [128];
    logic [15:0] log_d   [128];
    logic        log_ce  [128];
    logic        log_wr  [128];

    sysctl_icap_seq #(
        .SPI_OPCODE (8'h03),
        .TIMEOUT    (16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .reboot     (reboot),
        .boot_addr  (boot_addr),
        .raw_we     (raw_we),
        .raw_d      (raw_d),
        .raw_ce     (raw_ce),
        .raw_write  (raw_write),
        .busy       (busy),
        .timeout    (timeout),
        .icap_ready (icap_ready),
        .icap_we    (icap_we),
        .icap_d     (icap_d),
        .icap_ce    (icap_ce),
        .icap_write (icap_write)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Port model: ready low for the 5 cycles following each we.
    assign icap_ready = (port_cnt == 3'd0) && !force_low;

    always @(posedge sys_clk) begin
        if (we_q)
            port_cnt <= 3'd5;
        else if (port_cnt != 3'd0)
            port_cnt <= port_cnt - 3'd1;
    end

    always @(negedge sys_clk) begin
        we_q <= icap_we;
        if (icap_we === 1'b1) begin
            if (nlog < 128) begin
                log_cyc[nlog] = cyc;
                log_d[nlog]   = icap_d;
                log_ce[nlog]  = icap_ce;
                log_wr[nlog]  = icap_write;
            end
            nlog = nlog + 1;
        end
    end

    function automatic logic [15:0] exp_word(input int i, input logic [23:0] a);
        case (i)
            0:       return 16'hFFFF;
            1:       return 16'hAA99;
            2:       return 16'h5566;
            3:       return 16'h3261;
            4:       return a[15:0];
            5:       return 16'h3281;
            6:       return {8'h03, a[23:16]};
            7:       return 16'h30A1;
            8:       return 16'h000E;
            9:       return 16'h2000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_we(input int target, input int budget, output bit ok);
        int n = 0;
        while (nlog < target && n < budget) begin
            tick();
            n++;
        end
        ok = (nlog >= target);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic pulse_reboot(input logic [23:0] a);
        reboot    = 1'b1;
        boot_addr = a;
        tick();
        reboot    = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, timeout, icap_we, icap_ce, icap_write, icap_d} !== {5'b00011, 16'hFFFF}) begin
            failures++;
            $display("FAIL reset_in: busy/to/we/ce/wr/d=%b%b%b%b%b %h, required 00011 FFFF",
                     busy, timeout, icap_we, icap_ce, icap_write, icap_d);
        end
        sys_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, timeout, icap_we, icap_ce, icap_write, icap_d} !== {5'b00011, 16'hFFFF}) begin
            failures++;
            $display("FAIL reset_out: busy/to/we/ce/wr/d=%b%b%b%b%b %h, required 00011 FFFF",
                     busy, timeout, icap_we, icap_ce, icap_write, icap_d);
        end
    endtask

    task automatic test_sequence();
        int b = nlog;
        bit ok;
        pulse_reboot(24'h123456);
        wait_idle(200, ok);
        checks++;
        if (!ok || (nlog - b) !== 10) begin
            failures++;
            $display("FAIL seq_count: idle=%0d we_count=%0d, required idle=1 we_count=10", ok, nlog - b);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({log_d[b+i], log_ce[b+i], log_wr[b+i]} !== {exp_word(i, 24'h123456), 2'b00}) begin
                failures++;
                $display("FAIL seq_word%0d: d=%h ce=%b wr=%b, required d=%h ce=0 wr=0",
                         i, log_d[b+i], log_ce[b+i], log_wr[b+i], exp_word(i, 24'h123456));
            end
        end
        for (int i = 1; i < 10; i++) begin
            checks++;
            if (log_cyc[b+i] - log_cyc[b+i-1] !== 7) begin
                failures++;
                $display("FAIL seq_gap%0d: gap=%0d, required 7", i, log_cyc[b+i] - log_cyc[b+i-1]);
            end
        end
        checks++;
        if ({icap_ce, icap_write} !== 2'b11) begin
            failures++;
            $display("FAIL seq_idle_ctl: ce/wr=%b%b, required 11", icap_ce, icap_write);
        end
    endtask

    task automatic test_raw();
        int b = nlog;
        bit ok;
        raw_d     = 16'hBEEF;
        raw_ce    = 1'b0;
        raw_write = 1'b1;
        raw_we    = 1'b1;
        tick();
        raw_we    = 1'b0;
        wait_idle(50, ok);
        checks++;
        if (!ok || (nlog - b) !== 1) begin
            failures++;
            $display("FAIL raw_count: idle=%0d we_count=%0d, required idle=1 we_count=1", ok, nlog - b);
        end
        checks++;
        if ({log_d[b], log_ce[b], log_wr[b]} !== {16'hBEEF, 2'b01}) begin
            failures++;
            $display("FAIL raw_word: d=%h ce=%b wr=%b, required d=BEEF ce=0 wr=1",
                     log_d[b], log_ce[b], log_wr[b]);
        end
        checks++;
        if (cyc - log_cyc[b] !== 7) begin
            failures++;
            $display("FAIL raw_busy_drop: cycles after we=%0d, required 7", cyc - log_cyc[b]);
        end
    endtask

    task automatic test_ready_low();
        int b;
        bit ok;
        sys_rst_n = 1'b0;
        force_low = 1'b1;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        b = nlog;
        pulse_reboot(24'h123456);
        repeat (20) tick();
        checks++;
        if ({busy, timeout} !== 2'b10 || nlog !== b) begin
            failures++;
            $display("FAIL ready_low_hold: busy=%b timeout=%b we_count=%0d, required busy=1 timeout=0 we_count=0",
                     busy, timeout, nlog - b);
        end
        force_low = 1'b0;
        wait_we(b + 1, 10, ok);
        checks++;
        if (!ok || log_d[b] !== 16'hFFFF) begin
            failures++;
            $display("FAIL ready_low_first: seen=%0d d=%h, required seen=1 d=FFFF", ok, log_d[b]);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || (nlog - b) !== 10) begin
            failures++;
            $display("FAIL ready_low_count: idle=%0d we_count=%0d, required idle=1 we_count=10", ok, nlog - b);
        end
    endtask

    task automatic test_timeout();
        int  b = nlog;
        int  b2;
        int  to_cyc = -1;
        bit  ok;
        pulse_reboot(24'h00FF00);
        wait_we(b + 3, 50, ok);
        force_low = 1'b1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL to_three_we: we_count=%0d, required 3", nlog - b);
        end
        for (int k = 0; k < 40; k++) begin
            if (timeout === 1'b1) begin
                to_cyc = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (to_cyc - log_cyc[b+2] !== 18 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_timing: cycles after 3rd we=%0d busy=%b, required 18 busy=0",
                     to_cyc - log_cyc[b+2], busy);
        end
        repeat (10) tick();
        checks++;
        if (nlog !== b + 3 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: we_count=%0d timeout=%b, required we_count=3 timeout=1", nlog - b, timeout);
        end
        force_low = 1'b0;
        b2 = nlog;
        pulse_reboot(24'h00FF00);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: timeout=%b, required 0", timeout);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || (nlog - b2) !== 10 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_rerun: idle=%0d we_count=%0d timeout=%b, required idle=1 we_count=10 timeout=0",
                     ok, nlog - b2, timeout);
        end
    endtask

    task automatic test_collision();
        int b = nlog;
        raw_d     = 16'hDEAD;
        raw_ce    = 1'b0;
        raw_write = 1'b0;
        raw_we    = 1'b1;
        pulse_reboot(24'hABCDEF);
        for (int k = 0; k < 200 && busy; k++) begin
            raw_we = ((k % 9) == 0);
            tick();
        end
        raw_we = 1'b0;
        repeat (15) tick();
        checks++;
        if ((nlog - b) !== 10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL coll_count: we_count=%0d busy=%b, required we_count=10 busy=0", nlog - b, busy);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (log_d[b+i] !== exp_word(i, 24'hABCDEF)) begin
                failures++;
                $display("FAIL coll_word%0d: d=%h, required %h", i, log_d[b+i], exp_word(i, 24'hABCDEF));
            end
        end
    endtask

    task automatic test_mid_reset();
        int b = nlog;
        int b2;
        bit hit = 1'b0;
        bit ok;
        pulse_reboot(24'h123456);
        for (int k = 0; k < 100; k++) begin
            if (icap_we === 1'b1 && nlog == b + 5) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reach: sixth we not seen, we_count=%0d, required 5 logged + 1 active", nlog - b);
        end
        #1 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({icap_we, busy, icap_ce, icap_write, icap_d} !== {4'b0011, 16'hFFFF}) begin
            failures++;
            $display("FAIL mid_async: we/busy/ce/wr/d=%b%b%b%b %h, required 0011 FFFF",
                     icap_we, busy, icap_ce, icap_write, icap_d);
        end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        b2 = nlog;
        checks++;
        if (b2 !== b + 5) begin
            failures++;
            $display("FAIL mid_partial: we_count=%0d, required 5", b2 - b);
        end
        pulse_reboot(24'h123456);
        wait_idle(200, ok);
        checks++;
        if (!ok || (nlog - b2) !== 10) begin
            failures++;
            $display("FAIL mid_restart_count: idle=%0d we_count=%0d, required idle=1 we_count=10", ok, nlog - b2);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (log_d[b2+i] !== exp_word(i, 24'h123456)) begin
                failures++;
                $display("FAIL mid_word%0d: d=%h, required %h", i, log_d[b2+i], exp_word(i, 24'h123456));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_raw();
        test_ready_low();
        test_timeout();
        test_collision();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
